// File: rtl/pe_link_pkg.sv
// Shared widths and types for the inter-PE link buffer.
package pe_link_pkg;

   localparam int LINK_WIDTH        = 130;
   localparam int DEFAULT_ADDR_BITS = 7;

   typedef logic [DEFAULT_ADDR_BITS:0] count_t;

   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/pe_link_fifo_if.sv
// Link handshake bundle: write side (din) and head side (dout) of the buffer.
interface pe_link_fifo_if
   import pe_link_pkg::*;
#(
   parameter int DATA_WIDTH = LINK_WIDTH
);
   logic [DATA_WIDTH-1:0] din;
   logic                  din_valid;
   logic                  din_ready;
   logic [DATA_WIDTH-1:0] dout;
   logic                  dout_valid;
   logic                  dout_ready;

   modport master (
      output din, din_valid, dout_ready,
      input  din_ready, dout, dout_valid
   );

   modport slave (
      input  din, din_valid, dout_ready,
      output din_ready, dout, dout_valid
   );
endinterface

// File: rtl/pe_link_bram.sv
// Simple dual-port memory, one write port and one synchronous read port.
// The read-data register is cleared by reset/clear; the array itself is never reset.
module pe_link_bram #(
   parameter int DATA_WIDTH = 130,
   parameter int ADDR_BITS  = 7
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i_clr,
   input  logic                  i_we,
   input  logic [ADDR_BITS-1:0]  i_waddr,
   input  logic [DATA_WIDTH-1:0] i_wdata,
   input  logic                  i_re,
   input  logic [ADDR_BITS-1:0]  i_raddr,
   output logic [DATA_WIDTH-1:0] o_rdata
);
   localparam int DEPTH = 2 ** ADDR_BITS;

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [DATA_WIDTH-1:0] r_rdata;

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset || i_clr) begin
         r_rdata <= '0;
      end else if (i_re) begin
         r_rdata <= r_mem[i_raddr];
      end
   end

   assign o_rdata = r_rdata;
endmodule

// File: rtl/pe_link_fifo.sv
// First-word-fall-through elastic buffer on an inter-PE link; write-to-head latency 2 cycles.
// din_ready drops only when memory is full or flush/reset is active; PE_LINK_FIFO_STATS_EN adds max_count/stall_cycles.
module pe_link_fifo
   import pe_link_pkg::*;
#(
   parameter int DATA_WIDTH         = LINK_WIDTH,
   parameter int NUM_BRAM_ADDR_BITS = DEFAULT_ADDR_BITS
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          flush,
   pe_link_fifo_if.slave                 lnk,
   output logic [NUM_BRAM_ADDR_BITS:0]   count,
   output logic                          empty,
   output logic                          full
`ifdef PE_LINK_FIFO_STATS_EN
   ,
   output logic [NUM_BRAM_ADDR_BITS:0]   max_count,
   output logic [31:0]                   stall_cycles
`endif
);
   localparam int A     = NUM_BRAM_ADDR_BITS;
   localparam int DEPTH = 2 ** A;

   localparam logic [A:0]   DEPTH_C = (A+1)'(DEPTH);
   localparam logic [A:0]   OCC_ONE = (A+1)'(1);
   localparam logic [A-1:0] PTR_ONE = A'(1);

   logic [A-1:0]          r_wr_ptr;
   logic [A-1:0]          r_rd_ptr;
   logic [A:0]            r_occ;
   logic                  r_dout_valid;

   logic                  w_full;
   logic                  w_din_ready;
   logic                  w_wr;
   logic                  w_rd;
   logic [A:0]            w_count;
   logic [DATA_WIDTH-1:0] w_rdata;

   assign w_full      = (r_occ == DEPTH_C);
   // No write-through: a pop in the same cycle never frees a slot for a full memory.
   assign w_din_ready = reset & ~flush & ~w_full;
   assign w_wr        = lnk.din_valid & w_din_ready;
   assign w_rd        = (r_occ != '0) & (~r_dout_valid | lnk.dout_ready);
   assign w_count     = r_occ + {{A{1'b0}}, r_dout_valid};

   always_ff @(posedge clk) begin
      if (!reset || flush) begin
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_occ        <= '0;
         r_dout_valid <= 1'b0;
      end else begin
         if (w_wr) begin
            r_wr_ptr <= r_wr_ptr + PTR_ONE;
         end
         if (w_rd) begin
            r_rd_ptr <= r_rd_ptr + PTR_ONE;
         end
         case ({w_wr, w_rd})
            2'b10:   r_occ <= r_occ + OCC_ONE;
            2'b01:   r_occ <= r_occ - OCC_ONE;
            default: r_occ <= r_occ;
         endcase
         if (w_rd) begin
            r_dout_valid <= 1'b1;
         end else if (lnk.dout_ready) begin
            r_dout_valid <= 1'b0;
         end
      end
   end

   pe_link_bram #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_BITS  (A)
   ) u_bram (
      .clk     (clk),
      .reset   (reset),
      .i_clr   (flush),
      .i_we    (w_wr),
      .i_waddr (r_wr_ptr),
      .i_wdata (lnk.din),
      .i_re    (w_rd),
      .i_raddr (r_rd_ptr),
      .o_rdata (w_rdata)
   );

   assign lnk.din_ready  = w_din_ready;
   assign lnk.dout       = w_rdata;
   assign lnk.dout_valid = r_dout_valid;
   assign count          = w_count;
   assign empty          = (w_count == '0);
   assign full           = w_full;

`ifdef PE_LINK_FIFO_STATS_EN
   logic [A:0]  r_max_count;
   logic [31:0] r_stall_cycles;

   always_ff @(posedge clk) begin
      if (!reset || flush) begin
         r_max_count    <= '0;
         r_stall_cycles <= '0;
      end else begin
         if (w_count > r_max_count) begin
            r_max_count <= w_count;
         end
         if (lnk.din_valid && !w_din_ready) begin
            r_stall_cycles <= sat_inc32(r_stall_cycles);
         end
      end
   end

   assign max_count    = r_max_count;
   assign stall_cycles = r_stall_cycles;
`endif
endmodule

// File: tb/tb_pe_link_fifo.sv
// Randomised and directed bench for pe_link_fifo against a queue-based reference model.
module tb_pe_link_fifo;
   import pe_link_pkg::*;

   localparam int AW    = DEFAULT_ADDR_BITS;
   localparam int DEPTH = 2 ** AW;
   localparam int W     = LINK_WIDTH;

   logic   clk = 1'b0;
   logic   reset;
   logic   flush;
   count_t count;
   logic   empty;
   logic   full;
`ifdef PE_LINK_FIFO_STATS_EN
   logic [AW:0] max_count;
   logic [31:0] stall_cycles;
`endif

   always #5 clk = ~clk;

   pe_link_fifo_if #(.DATA_WIDTH(W)) lnk ();

   pe_link_fifo #(
      .DATA_WIDTH         (W),
      .NUM_BRAM_ADDR_BITS (AW)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .flush (flush),
      .lnk   (lnk),
      .count (count),
      .empty (empty),
      .full  (full)
`ifdef PE_LINK_FIFO_STATS_EN
      ,
      .max_count    (max_count),
      .stall_cycles (stall_cycles)
`endif
   );

   int errors = 0;
   int checks = 0;

   // Reference model: words in memory, plus the head slot presented on dout.
   logic [W-1:0] m_mem [$];
   logic         m_v;
   logic [W-1:0] m_d;
   int           m_max;
   logic [31:0]  m_stall;
   bit           mdl_on = 0;

   task automatic chk(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
      end
   endtask

   task automatic model_compare();
      int exp_cnt;
      if (!mdl_on) return;
      exp_cnt = m_mem.size() + int'(m_v);
      chk("m_dout_valid", W'(lnk.dout_valid), W'(m_v));
      if (m_v) chk("m_dout", lnk.dout, m_d);
      chk("m_count", W'(count), W'(exp_cnt));
      chk("m_empty", W'(empty), W'(exp_cnt == 0));
      chk("m_full", W'(full), W'(m_mem.size() == DEPTH));
      chk("m_din_ready", W'(lnk.din_ready), W'(reset && !flush && m_mem.size() < DEPTH));
`ifdef PE_LINK_FIFO_STATS_EN
      chk("m_max_count", W'(max_count), W'(m_max));
      chk("m_stall_cycles", W'(stall_cycles), W'(m_stall));
`endif
   endtask

   task automatic model_step();
      int pre_cnt;
      bit rdy;
      bit rd;
      pre_cnt = m_mem.size() + int'(m_v);
      rdy     = reset && !flush && (m_mem.size() < DEPTH);
      if (!reset || flush) begin
         m_mem.delete();
         m_v     = 1'b0;
         m_d     = '0;
         m_max   = 0;
         m_stall = '0;
      end else begin
         if (lnk.din_valid && !rdy && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
         if (pre_cnt > m_max) m_max = pre_cnt;
         rd = (m_mem.size() != 0) && (!m_v || lnk.dout_ready);
         if (rd) begin
            m_d = m_mem.pop_front();
            m_v = 1'b1;
         end else if (lnk.dout_ready) begin
            m_v = 1'b0;
         end
         if (lnk.din_valid && rdy) m_mem.push_back(lnk.din);
      end
      mdl_on = 1;
   endtask

   // One clock: compare on the falling edge, advance the model on the rising edge.
   task automatic tick();
      @(negedge clk);
      model_compare();
      @(posedge clk);
      model_step();
      #1;
   endtask

   // Stream an incrementing pattern with dout_ready low until n words are accepted.
   task automatic fill(input int n, output int acc);
      acc = 0;
      lnk.dout_ready = 1'b0;
      lnk.din_valid  = 1'b1;
      lnk.din        = '0;
      for (int c = 0; c < 400 && acc < n; c++) begin
         #1;
         if (lnk.din_ready) acc++;
         tick();
         lnk.din = W'(acc);
      end
   endtask

   task automatic rnd_word(output logic [W-1:0] v);
      v = {$urandom, $urandom, $urandom, $urandom, $urandom};
   endtask

   initial begin
      int acc;
      int extra;
      int bad;
      int cnt_bad;
      int exp;
      logic [W-1:0] rw;

      reset          = 1'b0;
      flush          = 1'b0;
      lnk.din        = '0;
      lnk.din_valid  = 1'b0;
      lnk.dout_ready = 1'b0;
      @(posedge clk);
      model_step();
      #1;
      tick();
      tick();

      // Reset state
      #1;
      chk("rst_dout_valid", W'(lnk.dout_valid), '0);
      chk("rst_dout", lnk.dout, '0);
      chk("rst_count", W'(count), '0);
      chk("rst_empty", W'(empty), W'(1));
      chk("rst_full", W'(full), '0);
      chk("rst_din_ready", W'(lnk.din_ready), '0);
      reset = 1'b1;
      #1;
      chk("rel_din_ready", W'(lnk.din_ready), W'(1));

      // Basic latency: word written in cycle 0 is at the head in cycle 2
      lnk.din       = W'(1);
      lnk.din_valid = 1'b1;
      tick();
      lnk.din_valid = 1'b0;
      #1;
      chk("lat_c1_valid", W'(lnk.dout_valid), '0);
      tick();
      chk("lat_c2_valid", W'(lnk.dout_valid), W'(1));
      chk("lat_c2_dout", lnk.dout, W'(1));
      chk("lat_c2_count", W'(count), W'(1));
      repeat (10) tick();
      chk("lat_hold_dout", lnk.dout, W'(1));
      chk("lat_hold_valid", W'(lnk.dout_valid), W'(1));
      flush = 1'b1;
      tick();
      flush = 1'b0;
      #1;
      chk("flush1_empty", W'(empty), W'(1));

      // Fill to capacity, then 5 stalled write attempts
      fill(DEPTH + 1, acc);
      extra = 0;
      for (int i = 0; i < 5; i++) begin
         if (lnk.din_ready) extra++;
         tick();
      end
      lnk.din_valid = 1'b0;
      #1;
      chk("fill_accepted", W'(acc + extra), W'(DEPTH + 1));
      chk("fill_full", W'(full), W'(1));
      chk("fill_count", W'(count), W'(DEPTH + 1));
      chk("fill_din_ready", W'(lnk.din_ready), '0);
`ifdef PE_LINK_FIFO_STATS_EN
      chk("st_max_count", W'(max_count), W'(DEPTH + 1));
      chk("st_stall", W'(stall_cycles), W'(5));
`endif

      // Full with simultaneous pop
      lnk.din        = W'(999);
      lnk.din_valid  = 1'b1;
      lnk.dout_ready = 1'b1;
      #1;
      chk("fp_din_ready", W'(lnk.din_ready), '0);
      chk("fp_head", lnk.dout, '0);
      tick();
      lnk.din_valid  = 1'b0;
      lnk.dout_ready = 1'b0;
      #1;
      chk("fp_count", W'(count), W'(DEPTH));
      chk("fp_din_ready_after", W'(lnk.din_ready), W'(1));
      chk("fp_head_after", lnk.dout, W'(1));

      // Drain 1..DEPTH, one per cycle
      lnk.dout_ready = 1'b1;
      bad = 0;
      exp = 1;
      for (int i = 0; i < DEPTH; i++) begin
         if (!lnk.dout_valid || lnk.dout !== W'(exp)) bad++;
         exp++;
         tick();
      end
      lnk.dout_ready = 1'b0;
      #1;
      chk("drain_order", W'(bad), '0);
      chk("drain_empty", W'(empty), W'(1));

      // Streaming with wrap
      lnk.din_valid  = 1'b1;
      lnk.dout_ready = 1'b1;
      bad     = 0;
      cnt_bad = 0;
      for (int c = 0; c < 1000; c++) begin
         lnk.din = W'(c);
         #1;
         if (c >= 2) begin
            if (!lnk.dout_valid || lnk.dout !== W'(c - 2)) bad++;
            if (count !== count_t'(2)) cnt_bad++;
         end
         tick();
      end
      lnk.din_valid = 1'b0;
      chk("stream_order", W'(bad), '0);
      chk("stream_count2", W'(cnt_bad), '0);

      // Randomised traffic with occasional flush/reset
      for (int c = 0; c < 4000; c++) begin
         int ph;
         ph = c / 400;
         rnd_word(rw);
         lnk.din        = rw;
         lnk.din_valid  = ($urandom_range(0, 3) != 0);
         lnk.dout_ready = (ph % 2 == 0) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 2) != 0);
         flush          = ($urandom_range(0, 299) == 0);
         reset          = ($urandom_range(0, 599) != 0);
         tick();
      end
      reset          = 1'b1;
      flush          = 1'b1;
      lnk.din_valid  = 1'b0;
      lnk.dout_ready = 1'b0;
      tick();
      flush = 1'b0;

      // Flush mid-operation with a concurrent write
      fill(50, acc);
      lnk.din_valid = 1'b0;
      #1;
      chk("fl_pre_count", W'(count), W'(50));
      flush         = 1'b1;
      lnk.din       = W'(12345);
      lnk.din_valid = 1'b1;
      #1;
      chk("fl_din_ready", W'(lnk.din_ready), '0);
      tick();
      flush         = 1'b0;
      lnk.din_valid = 1'b0;
      #1;
      chk("fl_count", W'(count), '0);
      chk("fl_dout_valid", W'(lnk.dout_valid), '0);
      chk("fl_empty", W'(empty), W'(1));
      chk("fl_dout", lnk.dout, '0);
`ifdef PE_LINK_FIFO_STATS_EN
      chk("fl_max_count", W'(max_count), '0);
      chk("fl_stall", W'(stall_cycles), '0);
`endif
      repeat (3) tick();
      chk("fl_word_lost", W'(empty), W'(1));

      // Reset mid-operation
      fill(50, acc);
      reset         = 1'b0;
      lnk.din       = W'(777);
      lnk.din_valid = 1'b1;
      #1;
      chk("rs_din_ready", W'(lnk.din_ready), '0);
      tick();
      lnk.din_valid = 1'b0;
      #1;
      chk("rs_count", W'(count), '0);
      chk("rs_dout_valid", W'(lnk.dout_valid), '0);
      chk("rs_empty", W'(empty), W'(1));
      tick();
      chk("rs_din_ready_low", W'(lnk.din_ready), '0);
      reset = 1'b1;
      #1;
      chk("rs_din_ready_rel", W'(lnk.din_ready), W'(1));
      repeat (3) tick();
      chk("rs_word_lost", W'(empty), W'(1));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
